dram_responder: RTL and testbench
=================================

// Module: dram_responder
// PURPOSE
//  Memory-side end of the Top DRAM ports: responds to dramra (read address), returns dramrd (read data), absorbs dramw (write).
//  Synthesizable stand-in for external DRAM; sits beside the accelerator in sim and FPGA bring-up.
//  Models a fixed access latency with bounded outstanding reads, so Top's stall paths get exercised.
// PARAMETERS
//  AW     10  word-address width; memory depth = 2**AW words
//  DW     32  data word width; multiple of 8
//  LAT    4   cycles from ra accept to earliest rd_rdy; range 1..15
//  QDEPTH 4   max outstanding reads (accepted, not yet acked on rd); power of 2, >=2
// PORTS
//  i_clk      in   1        clock
//  i_rst      in   1        reset
//  ra_rdy     in   1        read-address valid from Top
//  ra_ack     out  1        read address accepted
//  ra_addr    in   AW       read word address
//  rd_rdy     out  1        read data valid to Top
//  rd_ack     in   1        Top accepts read data
//  rd_data    out  DW       read data
//  w_rdy      in   1        write valid from Top
//  w_ack      out  1        write accepted
//  w_addr     in   AW       write word address
//  w_data     in   DW       write data
//  w_mask     in   DW/8     byte enables; 1 = write byte
// BEHAVIOUR
//  - One clock (i_clk); reset i_rst is synchronous and active-high.
//  - Handshake: a transfer happens in a cycle where rdy && ack. The sender holds rdy and payload until ack.
//    ra_ack and w_ack are combinational from internal state and rdy. rd_rdy and rd_data are registered.
//  - Reset values: ra_ack=0, w_ack=0, rd_rdy=0, rd_data=0, read queue empty, occupancy=0.
//    Memory array is not cleared.
//  - Reset mid-operation drops all queued and in-flight reads; no rd beat is issued for them.
//    Writes already acked stay in memory.
//  - Write path:
//    - w_ack = w_rdy && !i_rst.
//    - On w_rdy&&w_ack, bytes with w_mask[b]=1 are updated at the clock edge.
//    - Mask all-zero: accepted, no memory change.
//  - Read path: circular queue of QDEPTH entries {data[DW], cnt[4]}, plus occupancy counter occ (0..QDEPTH).
//    - ra_ack = ra_rdy && !i_rst && (occ < QDEPTH || pop_this_cycle). Full queue with a same-cycle pop still accepts.
//    - On accept, mem[ra_addr] is sampled that cycle and pushed with cnt=LAT-1.
//    - Read/write collision on the same address in the same cycle returns the OLD data; the write lands after.
//    - Each cycle, every valid entry with cnt>0 decrements cnt; cnt saturates at 0.
//    - rd_rdy=1 when the head entry is valid with cnt==0. The head is registered into rd_data.
//    - Earliest rd_rdy is LAT cycles after the accept cycle (accept at edge t => rd_rdy high in cycle t+LAT).
//    - Pop on rd_rdy&&rd_ack. The next entry, if matured, is presented the following cycle, so back-to-back 1 beat/cycle.
//    - Responses are returned strictly in request order.
//  - occ update: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo QDEPTH.
//  - rd_ack high while rd_rdy=0 is ignored.
//    With rd_rdy=1 and rd_ack=0, rd_data holds stable and entries behind the head keep counting down.
//  - Sustained throughput: 1 read/cycle when QDEPTH >= LAT+1; otherwise bounded by QDEPTH/LAT.
// TESTING
//  1. mem[5]=32'hCAFE0005, LAT=4; pulse ra (addr 5) accepted at cycle 10 -> rd_rdy first high at cycle 14, rd_data=32'hCAFE0005; ack drops rd_rdy next cycle.
//  2. rd_ack held 0; issue 5 reads (QDEPTH=4) -> 4 acked, ra_ack=0 on the 5th.
//     Raise rd_ack -> 5th accepted in the first pop cycle; data returned in address order.
//  3. Write addr 3 data 32'h11223344 mask 4'b0101 over old 32'hAABBCCDD -> read addr 3 returns 32'hAA22CC44.
//  4. Same-cycle write 32'h0 and read of addr 7 (old 32'h7) -> read returns 32'h7; a later read returns 32'h0.
//  5. Continuous ra_rdy with rd_ack=1, QDEPTH=8, LAT=4, 16 addresses -> 16 beats on consecutive cycles after the initial 4-cycle gap.
//  6. 3 reads in flight, assert i_rst 1 cycle -> rd_rdy=0, ra_ack=0 during reset; no stale beats after.
//     A new read then completes in LAT cycles.

Source files
------------

// File: rtl/dram_responder.sv
// dram_responder: synthesizable stand-in for external DRAM with byte-masked writes,
// fixed read latency and a bounded queue of in-order outstanding reads.
module dram_responder #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int LAT    = 4,
  parameter int QDEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              ra_rdy,
  output logic              ra_ack,
  input  logic [AW-1:0]     ra_addr,
  output logic              rd_rdy,
  input  logic              rd_ack,
  output logic [DW-1:0]     rd_data,
  input  logic              w_rdy,
  output logic              w_ack,
  input  logic [AW-1:0]     w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic [DW/8-1:0]   w_mask
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW = PW + 1;
  localparam int NB = DW / 8;
  localparam logic [3:0]    CNT_INIT = 4'(LAT - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(QDEPTH);

  logic [DW-1:0] mem_r    [0:(1<<AW)-1];
  logic [DW-1:0] q_data_r [0:QDEPTH-1];
  logic [3:0]    q_cnt_r  [0:QDEPTH-1];
  logic [3:0]    q_cnt_s  [0:QDEPTH-1];
  logic [PW-1:0] head_r, tail_r, head_s;
  logic [OW-1:0] occ_r, occ_s;
  logic [DW-1:0] rd_word_s, rd_data_s, rd_data_r;
  logic          rd_rdy_r, rdy_s, pop_s, push_s, wr_s;

  assign pop_s     = rd_rdy_r && rd_ack;
  assign ra_ack    = ra_rdy && !i_rst && ((occ_r < OCC_FULL) || pop_s);
  assign push_s    = ra_ack;
  assign w_ack     = w_rdy && !i_rst;
  assign wr_s      = w_ack;
  assign rd_word_s = mem_r[ra_addr];
  assign rd_rdy    = rd_rdy_r;
  assign rd_data   = rd_data_r;

  // Next-state of the read queue; rd_rdy/rd_data are registered from this view so the
  // head is presented the cycle its countdown reaches zero.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      q_cnt_s[i] = (push_s && (PW'(i) == tail_r)) ? CNT_INIT :
                   ((q_cnt_r[i] != 4'd0) ? (q_cnt_r[i] - 4'd1) : 4'd0);
    end
    head_s = pop_s ? (head_r + PW'(1'b1)) : head_r;
    case ({push_s, pop_s})
      2'b10:   occ_s = occ_r + OW'(1'b1);
      2'b01:   occ_s = occ_r - OW'(1'b1);
      default: occ_s = occ_r;
    endcase
    rdy_s = (occ_s != {OW{1'b0}}) && (q_cnt_s[head_s] == 4'd0);
    // A push landing directly at the new head has not been stored yet; bypass it.
    rd_data_s = (push_s && (tail_r == head_s)) ? rd_word_s : q_data_r[head_s];
  end

  // Queue control and registered read-response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_r    <= {PW{1'b0}};
      tail_r    <= {PW{1'b0}};
      occ_r     <= {OW{1'b0}};
      rd_rdy_r  <= 1'b0;
      rd_data_r <= {DW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_cnt_r[i] <= 4'd0;
      end
    end else begin
      head_r   <= head_s;
      tail_r   <= push_s ? (tail_r + PW'(1'b1)) : tail_r;
      occ_r    <= occ_s;
      rd_rdy_r <= rdy_s;
      if (rdy_s) begin
        rd_data_r <= rd_data_s;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        q_cnt_r[i] <= q_cnt_s[i];
      end
    end
  end

  // Storage: memory array and queued read words are never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mask[b]) begin
          mem_r[w_addr][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
    if (push_s) begin
      q_data_r[tail_r] <= rd_word_s;
    end
  end
endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: per-scenario tasks with randomized traffic checked against
// a cycle-indexed model (word array plus a queue of {data, due cycle}).
module tb_dram_responder;
  localparam int AW = 10, DW = 32, LAT = 4, Q = 8, NA = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            ra_rdy, ra_ack, rd_rdy, rd_ack, w_rdy, w_ack;
  logic [AW-1:0]   ra_addr, w_addr;
  logic [DW-1:0]   rd_data, w_data;
  logic [DW/8-1:0] w_mask;

  always #5 i_clk = ~i_clk;

  dram_responder #(.AW(AW), .DW(DW), .LAT(LAT), .QDEPTH(Q)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .ra_rdy(ra_rdy), .ra_ack(ra_ack), .ra_addr(ra_addr),
    .rd_rdy(rd_rdy), .rd_ack(rd_ack), .rd_data(rd_data),
    .w_rdy(w_rdy), .w_ack(w_ack), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] mem_m [NA];
  logic [DW-1:0] q_data [$];
  int            q_due  [$];

  // Model: a read accepted in cycle c may be delivered from cycle c+LAT, strictly in order.
  function automatic logic exp_rdy();
    if (q_due.size() == 0) return 1'b0;
    return (cyc >= q_due[0]);
  endfunction

  function automatic logic exp_ra_ack();
    return ra_rdy && !i_rst && ((q_due.size() < Q) || (exp_rdy() && rd_ack));
  endfunction

  // Advance the model across one clock edge using the inputs presented this cycle.
  task automatic tick();
    logic pop, push;
    logic [DW-1:0] rv;
    pop  = exp_rdy() && rd_ack;
    push = exp_ra_ack();
    rv   = mem_m[ra_addr[4:0]];
    if (i_rst) begin
      q_data.delete();
      q_due.delete();
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_due.pop_front());
      end
      if (push) begin
        q_data.push_back(rv);
        q_due.push_back(cyc + LAT);
      end
      if (w_rdy) begin
        for (int b = 0; b < DW/8; b++) begin
          if (w_mask[b]) mem_m[w_addr[4:0]][8*b +: 8] = w_data[8*b +: 8];
        end
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; ra_rdy = 1'b1; rd_ack = 1'b1; w_rdy = 1'b1;
    ra_addr = '0; w_addr = '0; w_data = 32'h12345678; w_mask = 4'hF;
    tick();
    tick();
    @(negedge i_clk);
    total++; if (rd_rdy !== 1'b0) begin bad++; $display("FAIL reset rd_rdy got=%b exp=0", rd_rdy); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset rd_data got=%h exp=0", rd_data); end
    total++; if (ra_ack !== 1'b0) begin bad++; $display("FAIL reset ra_ack got=%b exp=0", ra_ack); end
    total++; if (w_ack !== 1'b0) begin bad++; $display("FAIL reset w_ack got=%b exp=0", w_ack); end
    i_rst = 1'b0; ra_rdy = 1'b0; rd_ack = 1'b0; w_rdy = 1'b0;
    tick();
  endtask

  task automatic test_preload();
    for (int a = 0; a < NA; a++) begin
      w_rdy = 1'b1; w_addr = AW'(a); w_mask = 4'hF;
      case (a)
        3:       w_data = 32'hAABBCCDD;
        5:       w_data = 32'hCAFE0005;
        7:       w_data = 32'h00000007;
        9:       w_data = 32'h00000099;
        default: w_data = $urandom;
      endcase
      @(negedge i_clk);
      total++; if (w_ack !== 1'b1) begin bad++; $display("FAIL preload w_ack a=%0d got=%b exp=1", a, w_ack); end
      tick();
    end
    w_rdy = 1'b0;
  endtask

  task automatic test_single();
    int acc_cyc, first_beat, beats;
    logic [DW-1:0] got;
    acc_cyc = -1; first_beat = -1; beats = 0; got = '0;
    rd_ack = 1'b1; ra_addr = AW'(5);
    for (int i = 0; i < 12; i++) begin
      ra_rdy = (acc_cyc < 0);
      @(negedge i_clk);
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL single rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL single rd_data got=%h exp=%h", rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL single ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      if (ra_rdy && ra_ack) acc_cyc = cyc;
      if (rd_rdy && rd_ack) begin
        beats++;
        if (first_beat < 0) begin first_beat = cyc; got = rd_data; end
      end
      tick();
    end
    ra_rdy = 1'b0;
    total++; if (acc_cyc < 0 || first_beat - acc_cyc != LAT) begin bad++; $display("FAIL single latency got=%0d exp=%0d", first_beat - acc_cyc, LAT); end
    total++; if (got !== 32'hCAFE0005) begin bad++; $display("FAIL single data got=%h exp=cafe0005", got); end
    total++; if (beats != 1) begin bad++; $display("FAIL single beat_count got=%0d exp=1", beats); end
  endtask

  task automatic test_mask_collision();
    logic [DW-1:0] got [$];
    logic [DW-1:0] expv [4];
    expv[0] = 32'h00000007; expv[1] = 32'hAA22CC44; expv[2] = 32'h00000000; expv[3] = 32'h00000099;
    rd_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_rdy = 1'b0; ra_rdy = 1'b0; w_mask = 4'hF; w_data = '0; w_addr = '0; ra_addr = '0;
      case (i)
        0:       begin w_rdy = 1'b1; w_addr = AW'(3); w_data = 32'h11223344; w_mask = 4'b0101; end
        1:       begin w_rdy = 1'b1; w_addr = AW'(7); w_data = 32'h0; ra_rdy = 1'b1; ra_addr = AW'(7); end
        2:       begin ra_rdy = 1'b1; ra_addr = AW'(3); end
        3:       begin ra_rdy = 1'b1; ra_addr = AW'(7); end
        4:       begin w_rdy = 1'b1; w_addr = AW'(9); w_data = 32'hFFFFFFFF; w_mask = 4'b0000; end
        5:       begin ra_rdy = 1'b1; ra_addr = AW'(9); end
        default: begin ra_rdy = 1'b0; end
      endcase
      @(negedge i_clk);
      total++; if (w_ack !== (w_rdy && !i_rst)) begin bad++; $display("FAIL mask w_ack cyc=%0d got=%b exp=%b", cyc, w_ack, w_rdy); end
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL mask rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL mask rd_data got=%h exp=%h", rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL mask ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      if (rd_rdy && rd_ack) got.push_back(rd_data);
      tick();
    end
    w_rdy = 1'b0; ra_rdy = 1'b0;
    total++; if (got.size() != 4) begin bad++; $display("FAIL mask beat_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++; if (got[k] !== expv[k]) begin bad++; $display("FAIL mask beat%0d got=%h exp=%h", k, got[k], expv[k]); end
    end
  endtask

  task automatic test_full();
    int accepted, acc_last, pop1;
    logic [DW-1:0] got [$];
    accepted = 0; acc_last = -1; pop1 = -1;
    for (int i = 0; i < 30; i++) begin
      ra_rdy = (accepted < Q + 1); ra_addr = AW'(10 + accepted); rd_ack = (i >= 12);
      @(negedge i_clk);
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL full rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL full rd_data got=%h exp=%h", rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL full ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      if (i == 10) begin
        total++; if (ra_ack !== 1'b0) begin bad++; $display("FAIL full_block ra_ack got=%b exp=0", ra_ack); end
      end
      if (ra_rdy && ra_ack) begin
        accepted++;
        if (accepted == Q + 1) acc_last = cyc;
      end
      if (rd_rdy && rd_ack) begin
        if (pop1 < 0) pop1 = cyc;
        got.push_back(rd_data);
      end
      tick();
    end
    ra_rdy = 1'b0; rd_ack = 1'b0;
    total++; if (acc_last < 0 || acc_last != pop1) begin bad++; $display("FAIL full same_cycle_accept got=%0d exp=%0d", acc_last, pop1); end
    total++; if (got.size() != Q + 1) begin bad++; $display("FAIL full beat_count got=%0d exp=%0d", got.size(), Q + 1); end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] !== mem_m[10 + k]) begin bad++; $display("FAIL full order%0d got=%h exp=%h", k, got[k], mem_m[10 + k]); end
    end
  endtask

  task automatic test_back_to_back();
    int accepted, acc0, acc_end;
    int beat_cyc [$];
    logic [DW-1:0] got [$];
    accepted = 0; acc0 = -1; acc_end = -1;
    rd_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra_rdy = (accepted < 16); ra_addr = AW'(accepted);
      @(negedge i_clk);
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL b2b rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL b2b rd_data got=%h exp=%h", rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL b2b ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      if (ra_rdy && ra_ack) begin
        if (accepted == 0) acc0 = cyc;
        accepted++;
        acc_end = cyc;
      end
      if (rd_rdy && rd_ack) begin beat_cyc.push_back(cyc); got.push_back(rd_data); end
      tick();
    end
    ra_rdy = 1'b0;
    total++; if (acc_end - acc0 != 15) begin bad++; $display("FAIL b2b accept_span got=%0d exp=15", acc_end - acc0); end
    total++; if (beat_cyc.size() != 16) begin bad++; $display("FAIL b2b beat_count got=%0d exp=16", beat_cyc.size()); end
    for (int k = 0; k < beat_cyc.size(); k++) begin
      total++;
      if (beat_cyc[k] != acc0 + LAT + k || got[k] !== mem_m[k]) begin
        bad++; $display("FAIL b2b beat%0d cyc got=%0d exp=%0d data got=%h exp=%h", k, beat_cyc[k], acc0 + LAT + k, got[k], mem_m[k]);
      end
    end
  endtask

  task automatic test_random();
    logic held;
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        ra_rdy  = (i < 370) && ($urandom_range(0, 2) != 0);
        ra_addr = AW'($urandom_range(0, NA - 1));
      end
      rd_ack = (i >= 370) ? 1'b1 : ($urandom_range(0, 3) != 0);
      w_rdy  = (i < 370) && ($urandom_range(0, 3) == 0);
      w_addr = AW'($urandom_range(0, NA - 1));
      w_data = $urandom;
      w_mask = 4'($urandom_range(0, 15));
      @(negedge i_clk);
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL rand rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL rand rd_data cyc=%0d got=%h exp=%h", cyc, rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL rand ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      held = ra_rdy && !ra_ack;
      tick();
    end
    ra_rdy = 1'b0; w_rdy = 1'b0; rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, beats, beat_c;
    logic [DW-1:0] got;
    acc = -1; beats = 0; beat_c = -1; got = '0;
    for (int i = 0; i < 20; i++) begin
      i_rst   = (i == 3);
      ra_rdy  = (i < 4) || (i == 6);
      ra_addr = AW'((i == 6) ? 24 : 20 + i);
      rd_ack  = (i >= 4);
      @(negedge i_clk);
      total++; if (rd_rdy !== exp_rdy()) begin bad++; $display("FAIL rstmid rd_rdy cyc=%0d got=%b exp=%b", cyc, rd_rdy, exp_rdy()); end
      if (exp_rdy()) begin
        total++; if (rd_data !== q_data[0]) begin bad++; $display("FAIL rstmid rd_data got=%h exp=%h", rd_data, q_data[0]); end
      end
      total++; if (ra_ack !== exp_ra_ack()) begin bad++; $display("FAIL rstmid ra_ack cyc=%0d got=%b exp=%b", cyc, ra_ack, exp_ra_ack()); end
      if (i == 3 || i == 4) begin
        total++; if (rd_rdy !== 1'b0 || ra_ack !== 1'b0) begin bad++; $display("FAIL rstmid quiet i=%0d rd_rdy=%b ra_ack=%b exp=0", i, rd_rdy, ra_ack); end
      end
      if (ra_rdy && ra_ack && i == 6) acc = cyc;
      if (rd_rdy && rd_ack) begin beats++; beat_c = cyc; got = rd_data; end
      tick();
    end
    i_rst = 1'b0; ra_rdy = 1'b0; rd_ack = 1'b0;
    total++; if (beats != 1) begin bad++; $display("FAIL rstmid beat_count got=%0d exp=1", beats); end
    total++; if (acc < 0 || beat_c - acc != LAT) begin bad++; $display("FAIL rstmid latency got=%0d exp=%0d", beat_c - acc, LAT); end
    total++; if (got !== mem_m[24]) begin bad++; $display("FAIL rstmid data got=%h exp=%h", got, mem_m[24]); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single();
    test_mask_collision();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
